mips_boot_loader: RTL and testbench

- Program loader upstream of the MipsCPU; fills instruction memory before the core runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to the instruction-memory write port.
- Holds the CPU in reset until the image is fully loaded, and optionally verified.

---
 rtl/mips_boot_loader_if.sv | 22 ++
 rtl/mips_boot_loader.sv | 146 ++++++++++++++
 tb/tb_mips_boot_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// master = loader side (accepts bytes, drives imem writes); slave = the environment.
interface mips_boot_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_boot_loader.sv
// Boot loader: assembles little-endian words from a byte stream, writes them to imem, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing 32-bit sum word before the image is accepted.
module mips_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               reload,
    mips_boot_loader_if.master bus,
    output logic               cpu_reset,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    word_count
);
`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_CHK, ST_DONE, ST_ERROR} state_t;
`else
    typedef enum logic [2:0] {ST_HDR, ST_LOAD, ST_DONE, ST_ERROR} state_t;
`endif

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state_reg, state_next;
    logic [1:0]        byte_idx_reg;
    logic [ADDR_W:0]   n_reg;
    logic [ADDR_W:0]   word_count_reg;
    logic              in_ready_reg, in_ready_next;
    logic              imem_we_reg, we_next;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              done_reg, done_next;
    logic              error_reg, error_next;
    logic              cpu_reset_reg, cpu_reset_next;
    logic              accept, word_done, hdr_ok, last_word;
    logic [31:0]       word;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       sum_reg;
`endif

    // reload beats a coincident handshake, so the byte is simply not taken
    assign accept    = bus.in_valid && in_ready_reg && !reload;
    assign word_done = accept && (byte_idx_reg == 2'd3);
    assign hdr_ok    = (word != 32'd0) && (word <= 32'(MAX_WORDS));
    assign last_word = (word_count_reg + (ADDR_W+1)'(1)) == n_reg;

    // Lanes 0..2 hold the earlier bytes; lane 3 is the live in_data byte
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    lane_reg <= 8'd0;
                else if (accept && (byte_idx_reg == 2'(gi)))
                    lane_reg <= bus.in_data;
            end
        end
    endgenerate

    assign word = {bus.in_data, g_lane[2].lane_reg, g_lane[1].lane_reg, g_lane[0].lane_reg};

    always_comb begin
        state_next = state_reg;
        if (reload) begin
            state_next = ST_HDR;
        end else begin
            case (state_reg)
                ST_HDR:  if (word_done) state_next = hdr_ok ? ST_LOAD : ST_ERROR;
`ifdef BOOT_CHECKSUM_EN
                ST_LOAD: if (word_done && last_word) state_next = ST_CHK;
                ST_CHK:  if (word_done) state_next = (word == sum_reg) ? ST_DONE : ST_ERROR;
`else
                ST_LOAD: if (word_done && last_word) state_next = ST_DONE;
`endif
                default: state_next = state_reg;
            endcase
        end
    end

    // done/error follow the state one edge later, so done lands after the last write pulse
    always_comb begin
        in_ready_next  = (state_next != ST_DONE) && (state_next != ST_ERROR);
        we_next        = word_done && (state_reg == ST_LOAD);
        done_next      = !reload && (state_reg == ST_DONE);
        error_next     = !reload && (state_reg == ST_ERROR);
        cpu_reset_next = !done_next;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_HDR;
            byte_idx_reg   <= 2'd0;
            n_reg          <= '0;
            word_count_reg <= '0;
            in_ready_reg   <= 1'b0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= BASE;
            imem_wdata_reg <= 32'd0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            cpu_reset_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            imem_we_reg   <= we_next;
            done_reg      <= done_next;
            error_reg     <= error_next;
            cpu_reset_reg <= cpu_reset_next;
            if (reload) begin
                byte_idx_reg   <= 2'd0;
                word_count_reg <= '0;
            end else begin
                if (accept)
                    byte_idx_reg <= byte_idx_reg + 2'd1;
                if (word_done && (state_reg == ST_HDR))
                    n_reg <= word[ADDR_W:0];
                if (we_next) begin
                    imem_addr_reg  <= BASE + word_count_reg[ADDR_W-1:0];
                    imem_wdata_reg <= word;
                    word_count_reg <= word_count_reg + (ADDR_W+1)'(1);
                end
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sum_reg <= 32'd0;
        else if (reload || (word_done && (state_reg == ST_HDR)))
            sum_reg <= 32'd0;
        else if (we_next)
            sum_reg <= sum_reg + word;
    end
`endif

    assign bus.in_ready   = in_ready_reg;
    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;
    assign cpu_reset      = cpu_reset_reg;
    assign done           = done_reg;
    assign error          = error_reg;
    assign word_count     = word_count_reg;
endmodule

// File: tb/tb_mips_boot_loader.sv
// Randomized self-checking bench for mips_boot_loader against an image-level reference model.
module tb_mips_boot_loader;
    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
    localparam int BASE_ADDR = 0;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            reload = 1'b0;
    logic            cpu_reset, done, error;
    logic [ADDR_W:0] word_count;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_we_cyc  = 0;
    int done_cyc     = 0;
    logic done_seen  = 1'b0;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic [31:0]       img[$];

    mips_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    mips_boot_loader #(
        .ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clock(clock), .reset(reset), .reload(reload), .bus(bus),
        .cpu_reset(cpu_reset), .done(done), .error(error), .word_count(word_count)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Write log and done-rise time, sampled mid-cycle
    always @(negedge clock) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr_q.push_back(bus.imem_addr);
            wr_data_q.push_back(bus.imem_wdata);
            last_we_cyc = cyc;
        end
        if (done === 1'b1 && !done_seen) done_cyc = cyc;
        done_seen = (done === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit rdy;
        int waited;
        if (gaps) begin
            while ($urandom_range(1) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clock); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        do begin
            rdy = bus.in_ready;
            @(posedge clock); #1;
            waited++;
        end while (!rdy && waited < 50);
        if (!rdy) check("ready_timeout", 64'(rdy), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic do_reload(input bit with_byte);
        reload = 1'b1;
        if (with_byte) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
        end
        @(posedge clock); #1;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        check("rl_word_count", 64'(word_count), 64'd0);
        check("rl_done", 64'(done), 64'd0);
        check("rl_error", 64'(error), 64'd0);
        check("rl_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rl_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_imem_we", 64'(bus.imem_we), 64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'(BASE_ADDR));
        check("rst_imem_wdata", 64'(bus.imem_wdata), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
    endtask

    // Model: a valid header yields N writes of img[] at BASE+i; acceptance needs a valid header
    // (and, with the checksum option, a trailing word equal to the wrap-around sum).
    task automatic run_image(input logic [31:0] hdr, input bit gaps, input int chk_delta);
        bit          hdr_ok, exp_ok;
        int          n, waited;
        logic [31:0] sum;
        logic [ADDR_W-1:0] exp_addr;
        hdr_ok = (hdr != 32'd0) && (hdr <= 32'(MAX_WORDS));
        n      = hdr_ok ? int'(hdr) : 0;
        sum    = 32'd0;
        foreach (img[i]) sum += img[i];
        wr_addr_q.delete();
        wr_data_q.delete();
        send_word(hdr, gaps);
        exp_ok = 1'b0;
        if (hdr_ok) begin
            for (int i = 0; i < n; i++) send_word(img[i], gaps);
`ifdef BOOT_CHECKSUM_EN
            send_word(sum + 32'(chk_delta), gaps);
            exp_ok = (chk_delta == 0);
`else
            exp_ok = 1'b1;
`endif
        end
        waited = 0;
        while (!(done === 1'b1 || error === 1'b1) && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        check("finish_seen", 64'(done | error), 64'd1);
        repeat (2) begin @(posedge clock); #1; end
        check("wr_count", 64'(wr_data_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
            exp_addr = ADDR_W'(BASE_ADDR + i);
            check("wr_addr", 64'(wr_addr_q[i]), 64'(exp_addr));
            check("wr_data", 64'(wr_data_q[i]), 64'(img[i]));
        end
        check("word_count", 64'(word_count), 64'(n));
        check("done", 64'(done), 64'(exp_ok));
        check("error", 64'(error), 64'(!exp_ok));
        check("cpu_reset", 64'(cpu_reset), 64'(!exp_ok));
        check("in_ready_end", 64'(bus.in_ready), 64'd0);
`ifndef BOOT_CHECKSUM_EN
        if (exp_ok) check("done_latency", 64'(done_cyc - last_we_cyc), 64'd1);
`endif
        $display("[TB] image hdr=0x%08h gaps=%0b writes=%0d word_count=%0d done=%0b error=%0b",
                 hdr, gaps, wr_data_q.size(), word_count, done, error);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("ready_before_edge", 64'(bus.in_ready), 64'd0);
        @(posedge clock); #1;
        check("ready_rise", 64'(bus.in_ready), 64'd1);

        img = '{32'h20080005, 32'h2109000A};
        run_image(32'd2, 1'b0, 0);

        do_reload(1'b0);
        img.delete();
        run_image(32'd0, 1'b0, 0);
        do_reload(1'b0);
        run_image(32'h00000101, 1'b1, 0);

        // Same N=3 image with and without gaps
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom());
        do_reload(1'b0);
        run_image(32'd3, 1'b0, 0);
        do_reload(1'b0);
        run_image(32'd3, 1'b1, 0);

        for (int t = 0; t < 4; t++) begin
            n = int'($urandom_range(1, 8));
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom());
            do_reload(1'b0);
            run_image(32'(n), 1'b1, 0);
        end

        img.delete();
        for (int i = 0; i < MAX_WORDS; i++) img.push_back($urandom());
        do_reload(1'b0);
        run_image(32'(MAX_WORDS), 1'b0, 0);

        // reload mid-word, coinciding with a handshake, then a fresh N=1 image
        do_reload(1'b0);
        send_word(32'd4, 1'b1);
        send_word($urandom(), 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b1);
        check("partial_word_count", 64'(word_count), 64'd1);
        do_reload(1'b1);
        img = '{32'hDEADBEEF};
        run_image(32'd1, 1'b1, 0);

        // asynchronous reset while a write pulse is on the bus
        do_reload(1'b0);
        send_word(32'd3, 1'b0);
        send_word(32'h13572468, 1'b0);
        check("pre_rst_we", 64'(bus.imem_we), 64'd1);
        check("pre_rst_word_count", 64'(word_count), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("ready_rise_again", 64'(bus.in_ready), 64'd1);
        img = '{$urandom()};
        run_image(32'd1, 1'b1, 0);

        img = '{32'h00000001, 32'h00000002};
        do_reload(1'b0);
        run_image(32'd2, 1'b0, 0);
        do_reload(1'b0);
        run_image(32'd2, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
